// File: rtl/sobel_linebuf_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sobel_linebuf_ctrl_if
// Purpose  : Handshake and status bundle between the Sobel line-buffer
//            sequencer (slave side) and its stream environment (master side).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface sobel_linebuf_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             Start;
  logic             PixelValid;
  logic             PixelReady;
  logic             OutReady;
  logic             ShiftEnable;
  logic             WindowValid;
  logic [CNT_W-1:0] Col;
  logic [CNT_W-1:0] Row;
  logic             Busy;
  logic             FrameDone;

  // Environment: produces pixels and frame starts, consumes windows
  modport master (
    output Start, PixelValid, OutReady,
    input  PixelReady, ShiftEnable, WindowValid, Col, Row, Busy, FrameDone
  );

  // Sequencer
  modport slave (
    input  Start, PixelValid, OutReady,
    output PixelReady, ShiftEnable, WindowValid, Col, Row, Busy, FrameDone
  );
endinterface
`default_nettype wire

// File: rtl/sobel_linebuf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sobel_linebuf_ctrl
// Purpose  : Sequencer for the Sobel line-buffer datapath. Accepts a raster
//            pixel stream, drives the shared shift enable of the line FIFOs
//            and window registers, tracks Col/Row and strobes WindowValid
//            when the 3x3 window holds a complete, non-wrapping neighbourhood.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sobel_linebuf_ctrl #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int CNT_W      = 8
) (
  input  wire logic             CLK,
  input  wire logic             Reset,
  sobel_linebuf_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] c_ROW_FILL = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_TWO      = CNT_W'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_fill;     // one-hot copy of "state == FILL"
  logic             r_stream;   // one-hot copy of "state == STREAM"
  logic             r_busy;
  logic             r_done;
  logic             r_wvalid;

  logic             w_ready;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;

  // Ready depends on OutReady only while windows are being produced;
  // during prefill no window exists, so downstream stalls are irrelevant.
  assign w_ready    = r_fill | (r_stream & bus.OutReady);
  assign w_accept   = bus.PixelValid & w_ready;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);

  // Frame sequencer: state, position counters and registered status outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_fill   <= 1'b0;
      r_stream <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wvalid <= 1'b0;
    end else begin
      // Window is complete once two full lines are buffered and the
      // two columns to the left belong to the same line (pre-increment)
      r_wvalid <= w_accept & (r_row >= c_TWO) & (r_col >= c_TWO);
      r_done   <= 1'b0;

      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_state <= S_FILL;
            r_fill  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_accept && w_col_last && (r_row == c_ROW_FILL)) begin
            r_state  <= S_STREAM;
            r_fill   <= 1'b0;
            r_stream <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_accept && w_col_last && w_row_last) begin
            r_state  <= S_DONE;
            r_stream <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_fill   <= 1'b0;
          r_stream <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PixelReady  = w_ready;
  assign bus.ShiftEnable = w_accept;
  assign bus.WindowValid = r_wvalid;
  assign bus.Col         = r_col;
  assign bus.Row         = r_row;
  assign bus.Busy        = r_busy;
  assign bus.FrameDone   = r_done;

endmodule
`default_nettype wire
